// File: rtl/dnn_pkg.sv
// Shared state type and width/reduction helpers for the DNN/GNN node engine.
// The helpers are evaluated at elaboration for port widths and in the output reduction path.
package dnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_MAC,
    ST_L1_DRAIN,
    ST_WAIT_AGGR,
    ST_L2_MAC,
    ST_L2_DRAIN,
    ST_OUT_HOLD
  } dnn_eng_state_t;

  function automatic int h_w(input int x_w, input int w_w, input int n_in);
    return x_w + w_w + $clog2(n_in);
  endfunction

  function automatic int l2_w(input int agg_w, input int w_w, input int n_hid);
    return agg_w + w_w + $clog2(n_hid);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp to the signed out_w range when sat is set, otherwise keep the low out_w bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int out_w, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    res = v;
    if (sat) begin
      if (v > hi) res = hi;
      else if (v < lo) res = lo;
    end else begin
      res = (v <<< (64 - out_w)) >>> (64 - out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/dnn_dot_lane.sv
// One dot-product lane: registered signed products followed by a combinational adder tree.
// Unused terms are fed zero weights by the caller so one lane width serves both layers.
module dnn_dot_lane #(
  parameter int N_TERMS = 4,
  parameter int A_W     = 17,
  parameter int W_W     = 5,
  parameter int SUM_W   = 24
) (
  input  logic                    clk,
  input  logic signed [A_W-1:0]   i_a [N_TERMS],
  input  logic signed [W_W-1:0]   i_w [N_TERMS],
  output logic signed [SUM_W-1:0] o_sum
);

  localparam int P_W = A_W + W_W;

  logic signed [P_W-1:0] r_prod [N_TERMS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TERMS; i++) begin
      r_prod[i] <= P_W'(i_a[i]) * P_W'(i_w[i]);
    end
  end

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      o_sum = o_sum + SUM_W'(r_prod[i]);
    end
  end

endmodule

// File: rtl/dnn_gnn_tmux_engine.sv
// Two-layer DNN/GNN node engine: LANES dot-product lanes are time-shared over a ReLU hidden
// layer and a linear output layer, with an external aggregation step between the two.
module dnn_gnn_tmux_engine
  import dnn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int LANES = 2,
  parameter int X_W   = 7,
  parameter int W_W   = 5,
  parameter int AGG_W = 17,
  parameter int OUT_W = 21,
  parameter int SAT   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_IN*X_W-1:0]                   x,
  input  logic [N_HID*N_IN*W_W-1:0]             w_l1,
  input  logic [N_OUT*N_HID*W_W-1:0]            w_l2,
  output logic                                  hid_valid,
  output logic [N_HID*h_w(X_W,W_W,N_IN)-1:0]    hid_relu,
  input  logic                                  aggr_valid,
  input  logic [N_HID*AGG_W-1:0]                aggr,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_OUT*OUT_W-1:0]                out
);

  localparam int H_W    = h_w(X_W, W_W, N_IN);
  localparam int P1     = ceil_div(N_HID, LANES);
  localparam int P2     = ceil_div(N_OUT, LANES);
  localparam int N_T    = max2(N_IN, N_HID);
  localparam int SUM_W  = AGG_W + W_W + $clog2(N_T);
  localparam int PASS_W = $clog2(max2(P1, P2)) + 1;
  localparam logic [PASS_W-1:0] LAST1 = PASS_W'(P1 - 1);
  localparam logic [PASS_W-1:0] LAST2 = PASS_W'(P2 - 1);

  dnn_eng_state_t r_state;
  logic r_inReady, r_hidValid, r_outValid;
  logic r_wrEn, r_wrL2;
  logic [PASS_W-1:0] r_pass, r_wrPass;
  logic signed [X_W-1:0]   r_x    [N_IN];
  logic signed [W_W-1:0]   r_w1   [N_HID][N_IN];
  logic signed [W_W-1:0]   r_w2   [N_OUT][N_HID];
  logic signed [AGG_W-1:0] r_aggr [N_HID];
  logic signed [H_W-1:0]   r_hid  [N_HID];
  logic signed [OUT_W-1:0] r_out  [N_OUT];

  logic signed [AGG_W-1:0] w_a   [LANES][N_T];
  logic signed [W_W-1:0]   w_w   [LANES][N_T];
  logic signed [SUM_W-1:0] w_sum [LANES];

  // Lane l of the current pass works on node r_pass*LANES+l; nodes past the end see zero weights.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < N_T; i++) begin
        w_a[l][i] = '0;
        w_w[l][i] = '0;
      end
      if (r_state == ST_L1_MAC) begin
        for (int i = 0; i < N_IN; i++) begin
          w_a[l][i] = AGG_W'(r_x[i]);
          for (int j = 0; j < N_HID; j++)
            if (j == int'(r_pass) * LANES + l) w_w[l][i] = r_w1[j][i];
        end
      end else if (r_state == ST_L2_MAC) begin
        for (int i = 0; i < N_HID; i++) begin
          w_a[l][i] = r_aggr[i];
          for (int k = 0; k < N_OUT; k++)
            if (k == int'(r_pass) * LANES + l) w_w[l][i] = r_w2[k][i];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dnn_dot_lane #(.N_TERMS(N_T), .A_W(AGG_W), .W_W(W_W), .SUM_W(SUM_W)) u_lane (
      .clk  (clk),
      .i_a  (w_a[l]),
      .i_w  (w_w[l]),
      .o_sum(w_sum[l])
    );
  end

  // The write-back stage trails issue by one cycle, so r_wr* carries the pass that was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inReady  <= 1'b1;
      r_hidValid <= 1'b0;
      r_outValid <= 1'b0;
      r_wrEn     <= 1'b0;
      r_wrL2     <= 1'b0;
      r_pass     <= '0;
      r_wrPass   <= '0;
      for (int j = 0; j < N_HID; j++) r_hid[j] <= '0;
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else begin
      r_wrEn <= 1'b0;
      if (r_wrEn) begin
        for (int l = 0; l < LANES; l++) begin
          if (!r_wrL2) begin
            for (int j = 0; j < N_HID; j++)
              if (j == int'(r_wrPass) * LANES + l)
                r_hid[j] <= w_sum[l][SUM_W-1] ? '0 : w_sum[l][H_W-1:0];
          end else begin
            for (int k = 0; k < N_OUT; k++)
              if (k == int'(r_wrPass) * LANES + l)
                r_out[k] <= OUT_W'(sat_trunc(64'(w_sum[l]), OUT_W, SAT != 0));
          end
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= x[i*X_W +: X_W];
            for (int j = 0; j < N_HID; j++)
              for (int i = 0; i < N_IN; i++) r_w1[j][i] <= w_l1[(j*N_IN+i)*W_W +: W_W];
            for (int k = 0; k < N_OUT; k++)
              for (int j = 0; j < N_HID; j++) r_w2[k][j] <= w_l2[(k*N_HID+j)*W_W +: W_W];
            r_pass    <= '0;
            r_inReady <= 1'b0;
            r_state   <= ST_L1_MAC;
          end
        end
        ST_L1_MAC, ST_L2_MAC: begin
          r_wrEn   <= 1'b1;
          r_wrPass <= r_pass;
          r_wrL2   <= (r_state == ST_L2_MAC);
          if (r_state == ST_L1_MAC && r_pass == LAST1) r_state <= ST_L1_DRAIN;
          else if (r_state == ST_L2_MAC && r_pass == LAST2) r_state <= ST_L2_DRAIN;
          else r_pass <= r_pass + 1'b1;
        end
        ST_L1_DRAIN: begin
          r_hidValid <= 1'b1;
          r_state    <= ST_WAIT_AGGR;
        end
        ST_WAIT_AGGR: begin
          if (aggr_valid) begin
            for (int j = 0; j < N_HID; j++) r_aggr[j] <= aggr[j*AGG_W +: AGG_W];
            r_pass     <= '0;
            r_hidValid <= 1'b0;
            r_state    <= ST_L2_MAC;
          end
        end
        ST_L2_DRAIN: begin
          r_outValid <= 1'b1;
          r_state    <= ST_OUT_HOLD;
        end
        ST_OUT_HOLD: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hid_relu = '0;
    out      = '0;
    for (int j = 0; j < N_HID; j++) hid_relu[j*H_W +: H_W] = r_hid[j];
    for (int k = 0; k < N_OUT; k++) out[k*OUT_W +: OUT_W] = r_out[k];
  end

  assign in_ready  = r_inReady;
  assign hid_valid = r_hidValid;
  assign out_valid = r_outValid;

endmodule
